io_pad_ctrl: RTL and testbench

//  Parametrised pad controller replacing per-interface tri-state glue (GPIO/I2C/USB).
//  N pins, each with a per-pin mode: input, push-pull, open-drain, or open-drain with pull-up.

---
 rtl/io_pad_pkg.sv | 15 +
 rtl/io_pad_chan.sv | 107 ++++++++++
 rtl/io_pad_ctrl.sv | 71 +++++++
 tb/tb_io_pad_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// io_pad_pkg - shared pad-mode type and default sizing for the pad controller.
package io_pad_pkg;

   typedef enum logic [1:0] {
      PAD_IN    = 2'b00,
      PAD_PP    = 2'b01,
      PAD_OD    = 2'b10,
      PAD_OD_PU = 2'b11
   } pad_mode_t;

   localparam int DEF_NUM_PINS    = 24;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DEB_W       = 16;

endpackage

// File: rtl/io_pad_chan.sv
// io_pad_chan - one pad channel: output encode, synchroniser, debounce, edge/pending logic.
module io_pad_chan
   import io_pad_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic      clk,
   input  logic      rst_n,
   input  pad_mode_t mode_i,
   input  logic      out_i,
   input  logic      tick_i,
   input  logic      deb_en_i,
   input  logic      rise_en_i,
   input  logic      fall_en_i,
   input  logic      irq_clr_i,
   input  logic      pad_in_i,
   output logic      pad_out_o,
   output logic      pad_oe_o,
   output logic      pup_o,
   output logic      in_o,
   output logic      pend_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             hist_q, hist_d;
   logic                   in_q, in_d;
   logic                   prev_q;
   logic                   pend_q, pend_d;
   logic                   out_q, out_d;
   logic                   oe_q, oe_d;
   logic                   pup_q, pup_d;
   logic                   sync_s;
   logic                   rise, fall;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_in_i};

      // History shifts regardless of deb_en so enabling debounce starts from real samples.
      hist_d = hist_q;
      if (tick_i) begin
         hist_d = {hist_q[0], sync_s};
      end

      in_d = in_q;
      if (!deb_en_i) begin
         in_d = sync_s;
      end else if (tick_i && (hist_q == {2{sync_s}})) begin
         in_d = sync_s;
      end

      rise   = ~prev_q & in_q;
      fall   = prev_q & ~in_q;
      pend_d = (pend_q & ~irq_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);

      out_d = 1'b0;
      oe_d  = 1'b0;
      pup_d = 1'b0;
      case (mode_i)
         PAD_PP: begin
            out_d = out_i;
            oe_d  = 1'b1;
         end
         PAD_OD: begin
            oe_d = ~out_i;
         end
         PAD_OD_PU: begin
            oe_d  = ~out_i;
            pup_d = 1'b1;
         end
         default: begin
            out_d = 1'b0;
            oe_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= '0;
         in_q   <= 1'b0;
         prev_q <= 1'b0;
         pend_q <= 1'b0;
         out_q  <= 1'b0;
         oe_q   <= 1'b0;
         pup_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         in_q   <= in_d;
         prev_q <= in_q;
         pend_q <= pend_d;
         out_q  <= out_d;
         oe_q   <= oe_d;
         pup_q  <= pup_d;
      end
   end

   assign pad_out_o = out_q;
   assign pad_oe_o  = oe_q;
   assign pup_o     = pup_q;
   assign in_o      = in_q;
   assign pend_o    = pend_q;

endmodule

// File: rtl/io_pad_ctrl.sv
// io_pad_ctrl - N-pin pad controller: shared debounce prescaler, per-pin channels, irq reduce.
module io_pad_ctrl
   import io_pad_pkg::*;
#(
   parameter int NUM_PINS    = DEF_NUM_PINS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_W       = DEF_DEB_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*NUM_PINS-1:0] mode_i,
   input  logic [NUM_PINS-1:0]   out_i,
   input  logic [DEB_W-1:0]      deb_div_i,
   input  logic [NUM_PINS-1:0]   deb_en_i,
   input  logic [NUM_PINS-1:0]   irq_rise_en_i,
   input  logic [NUM_PINS-1:0]   irq_fall_en_i,
   input  logic [NUM_PINS-1:0]   irq_clr_i,
   input  logic [NUM_PINS-1:0]   pad_in_i,
   output logic [NUM_PINS-1:0]   pad_out_o,
   output logic [NUM_PINS-1:0]   pad_oe_o,
   output logic [NUM_PINS-1:0]   pup_o,
   output logic [NUM_PINS-1:0]   in_o,
   output logic [NUM_PINS-1:0]   irq_pend_o,
   output logic                  irq_o
);

   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic             irq_q;

   // Lowering deb_div_i below the live count lets the counter run to its natural rollover.
   always_comb begin
      tick  = (cnt_q == deb_div_i);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         irq_q <= |irq_pend_o;
      end
   end

   assign irq_o = irq_q;

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_chan
      io_pad_chan #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .mode_i    (pad_mode_t'(mode_i[2*i +: 2])),
         .out_i     (out_i[i]),
         .tick_i    (tick),
         .deb_en_i  (deb_en_i[i]),
         .rise_en_i (irq_rise_en_i[i]),
         .fall_en_i (irq_fall_en_i[i]),
         .irq_clr_i (irq_clr_i[i]),
         .pad_in_i  (pad_in_i[i]),
         .pad_out_o (pad_out_o[i]),
         .pad_oe_o  (pad_oe_o[i]),
         .pup_o     (pup_o[i]),
         .in_o      (in_o[i]),
         .pend_o    (irq_pend_o[i])
      );
   end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// tb_io_pad_ctrl - directed vectors, corner sequences and a scoreboard run for io_pad_ctrl.
module tb_io_pad_ctrl;
   import io_pad_pkg::*;

   localparam int N = 24;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [2*N-1:0] mode;
   logic [N-1:0]   out_v, deb_en, rise_en, fall_en, clr, pad;
   logic [15:0]    deb_div;
   logic [N-1:0]   pad_out, pad_oe, pup, in_v, pend;
   logic           irq;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] m_s0, m_s1, m_h0, m_h1, m_in, m_prev, m_pend;
   logic [15:0]  m_cnt;
   logic         m_irq;

   typedef struct {
      pad_mode_t  md;
      logic       o;
      logic       e_oe;
      logic       e_out;
      logic       e_pup;
   } vec_t;

   vec_t vecs [8];

   io_pad_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_i        (mode),
      .out_i         (out_v),
      .deb_div_i     (deb_div),
      .deb_en_i      (deb_en),
      .irq_rise_en_i (rise_en),
      .irq_fall_en_i (fall_en),
      .irq_clr_i     (clr),
      .pad_in_i      (pad),
      .pad_out_o     (pad_out),
      .pad_oe_o      (pad_oe),
      .pup_o         (pup),
      .in_o          (in_v),
      .irq_pend_o    (pend),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_s0 = '0; m_s1 = '0; m_h0 = '0; m_h1 = '0;
      m_in = '0; m_prev = '0; m_pend = '0; m_cnt = '0; m_irq = 1'b0;
   endtask

   // Advance one clock; the reference model computes its next state from the inputs before the edge.
   task automatic step();
      logic         tk;
      logic [N-1:0] n_in, n_pend, n_h0, n_h1;
      logic [15:0]  n_cnt;
      tk    = (m_cnt == deb_div);
      n_cnt = tk ? 16'd0 : m_cnt + 16'd1;
      for (int b = 0; b < N; b++) begin
         if (!deb_en[b])
            n_in[b] = m_s1[b];
         else if (tk && m_h1[b] == m_s1[b] && m_h0[b] == m_s1[b])
            n_in[b] = m_s1[b];
         else
            n_in[b] = m_in[b];
         n_h1[b] = tk ? m_h0[b] : m_h1[b];
         n_h0[b] = tk ? m_s1[b] : m_h0[b];
         n_pend[b] = (m_pend[b] && !clr[b])
                   || (!m_prev[b] && m_in[b] && rise_en[b])
                   || (m_prev[b] && !m_in[b] && fall_en[b]);
      end
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         m_irq  = |m_pend;
         m_prev = m_in;
         m_in   = n_in;
         m_pend = n_pend;
         m_h1   = n_h1;
         m_h0   = n_h0;
         m_s1   = m_s0;
         m_s0   = pad;
         m_cnt  = n_cnt;
      end
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      vecs[0] = '{PAD_IN,    1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{PAD_PP,    1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{PAD_PP,    1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{PAD_OD,    1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{PAD_OD,    1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{PAD_OD_PU, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{PAD_OD_PU, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{PAD_IN,    1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; mode = '0; out_v = '1; deb_div = 16'd0; deb_en = '0;
      rise_en = '0; fall_en = '0; clr = '0; pad = '0;
      model_clear();

      // Reset with pads and modes wiggling
      for (int k = 0; k < 5; k++) begin
         pad  = N'($urandom);
         mode = {$urandom, $urandom};
         step();
      end
      chk("rst_in",   32'(in_v),    32'h0);
      chk("rst_oe",   32'(pad_oe),  32'h0);
      chk("rst_out",  32'(pad_out), 32'h0);
      chk("rst_pup",  32'(pup),     32'h0);
      chk("rst_pend", 32'(pend),    32'h0);
      chk("rst_irq",  32'(irq),     32'h0);

      rst_n = 1'b1; mode = '0; out_v = '0; pad = 24'h000001;
      steps(2);
      chk("rel_in0_c2", 32'(in_v[0]), 32'h0);
      step();
      chk("rel_in0_c3", 32'(in_v[0]), 32'h1);
      steps(4);
      chk("rel_pend0", 32'(pend[0]), 32'h0);
      chk("rel_irq",   32'(irq),     32'h0);

      // Output mode table on pin 5
      for (int v = 0; v < 8; v++) begin
         mode[11:10] = vecs[v].md;
         out_v[5]    = vecs[v].o;
         step();
         chk($sformatf("mode%0d_oe", v),  32'(pad_oe),  32'(vecs[v].e_oe)  << 5);
         chk($sformatf("mode%0d_out", v), 32'(pad_out), 32'(vecs[v].e_out) << 5);
         chk($sformatf("mode%0d_pup", v), 32'(pup),     32'(vecs[v].e_pup) << 5);
      end

      // Debounce on pin 2, tick every 4 cycles
      deb_div = 16'd3; deb_en[2] = 1'b1;
      steps(12);
      pad[2] = 1'b1;
      steps(4);
      pad[2] = 1'b0;
      steps(12);
      chk("deb_glitch", 32'(in_v[2]), 32'h0);
      pad[2] = 1'b1;
      steps(6);
      chk("deb_early", 32'(in_v[2]), 32'h0);
      steps(12);
      chk("deb_follow", 32'(in_v[2]), 32'h1);
      deb_div = 16'd0; deb_en = '0;

      // Rising edge on pin 7
      rise_en[7] = 1'b1;
      pad[7] = 1'b1;
      steps(3);
      chk("rise_in",    32'(in_v[7]), 32'h1);
      chk("rise_pend0", 32'(pend[7]), 32'h0);
      step();
      chk("rise_pend1", 32'(pend[7]), 32'h1);
      chk("rise_irq0",  32'(irq),     32'h0);
      step();
      chk("rise_irq1",  32'(irq),     32'h1);
      clr[7] = 1'b1;
      step();
      clr[7] = 1'b0;
      chk("clr_pend", 32'(pend[7]), 32'h0);
      chk("clr_irqlag", 32'(irq),   32'h1);
      step();
      chk("clr_irq", 32'(irq), 32'h0);
      pad[7] = 1'b0;
      steps(6);
      chk("fall_noevt", 32'(pend), 32'h0);
      fall_en[7] = 1'b1;
      steps(4);
      chk("static_en", 32'(pend), 32'h0);
      fall_en[7] = 1'b0;

      // Clear colliding with a new rise: set wins
      pad[7] = 1'b1;
      steps(3);
      clr[7] = 1'b1;
      step();
      clr[7] = 1'b0;
      chk("collide_pend", 32'(pend[7]), 32'h1);
      steps(2);
      clr[7] = 1'b1;
      step();
      clr[7] = 1'b0;
      chk("late_clr", 32'(pend[7]), 32'h0);
      step();
      chk("late_irq", 32'(irq), 32'h0);

      // Scoreboard run with async reset in the middle
      deb_div = 16'd2;
      rise_en = N'($urandom);
      fall_en = N'($urandom);
      for (int i = 0; i < 10000 && bad < 20; i++) begin
         if (i % 500 == 0) begin
            deb_en = N'($urandom);
            mode   = {$urandom, $urandom};
         end
         pad   = pad ^ N'($urandom & $urandom & $urandom);
         out_v = N'($urandom);
         clr   = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
         if (i == 5000) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            chk("arst_in",   32'(in_v),   32'h0);
            chk("arst_pend", 32'(pend),   32'h0);
            chk("arst_irq",  32'(irq),    32'h0);
            chk("arst_oe",   32'(pad_oe), 32'h0);
            model_clear();
            steps(2);
            rst_n = 1'b1;
         end
         step();
         chk("sb_in",   32'(in_v), 32'(m_in));
         chk("sb_pend", 32'(pend), 32'(m_pend));
         chk("sb_irq",  32'(irq),  32'(m_irq));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
